// File: rtl/hs_deserializer_pkg.sv
// ============================================================================
// hs_deserializer_pkg : shared defaults and FSM state type for hs_deserializer
// Revision 1.0
// ============================================================================
`default_nettype none

package hs_deserializer_pkg;

  localparam int unsigned c_def_width = 8;
  localparam int unsigned c_def_depth = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hs_deserializer_sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock word FIFO with occupancy count, head word zeroed when empty
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned      c_aw       = $clog2(DEPTH);
  localparam logic [c_aw:0]    c_full_lvl = (c_aw+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == c_full_lvl);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/hs_deserializer.sv
// ============================================================================
// hs_deserializer : 4-phase serial handshake receiver assembling LSB-first words into a FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module hs_deserializer
  import hs_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = c_def_width,
  parameter int unsigned DEPTH = c_def_depth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send,
  input  logic                   data,
  output logic                   ack,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned      c_cw   = $clog2(WIDTH);
  localparam logic [c_cw-1:0]  c_last = c_cw'(WIDTH - 1);

  logic             r_send_s1, r_send_s2;
  logic             r_data_s1, r_data_s2;
  state_t           r_state, w_next_state;
  logic             r_ack;
  logic [c_cw-1:0]  r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_full, w_empty, w_accept, w_capture, w_push;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_send_s1 <= 1'b0;
      r_send_s2 <= 1'b0;
      r_data_s1 <= 1'b0;
      r_data_s2 <= 1'b0;
    end else begin
      r_send_s1 <= send;
      r_send_s2 <= r_send_s1;
      r_data_s1 <= data;
      r_data_s2 <= r_data_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ack   <= (w_next_state == HOLD);
    end
  end

  // The last bit of a word is only accepted when the FIFO has room for it.
  assign w_accept = !((r_bit_cnt == c_last) && w_full);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (r_send_s2 && w_accept) w_next_state = HOLD;
      HOLD:    if (!r_send_s2)            w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_capture         = (r_state == IDLE) && (w_next_state == HOLD);
    w_push            = w_capture && (r_bit_cnt == c_last);
    w_word            = r_shift;
    w_word[r_bit_cnt] = r_data_s2;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_capture) begin
      if (r_bit_cnt == c_last) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + c_cw'(1);
        r_shift   <= w_word;
      end
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_word),
    .i_pop       (out_ready),
    .o_pop_data  (out_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (level)
  );

  assign ack       = r_ack;
  assign out_valid = !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_hs_deserializer.sv
// ============================================================================
// tb_hs_deserializer : randomized handshake sender with word scoreboard for hs_deserializer
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hs_deserializer;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   send = 1'b0;
  logic                   data = 1'b0;
  logic                   out_ready = 1'b0;
  logic                   ack;
  logic                   out_valid;
  logic [W-1:0]           out_data;
  logic [$clog2(D):0]     level;

  int checks   = 0;
  int errors   = 0;
  int received = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  hs_deserializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .data      (data),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard: every accepted head word must be the oldest outstanding word.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %0h expected no word", out_data);
      end else begin
        check("fifo_word", out_data, exp_q.pop_front());
        received++;
      end
    end
  end

  task automatic wait_ack_low();
    int n = 0;
    while (ack && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (ack) fail_now("ack_release");
  endtask

  task automatic send_bit(input logic b, input bit chk_lat, input bit pop_on_cap);
    int n = 0;
    @(posedge clk); #($urandom_range(1, 4));
    data = b;
    #1 send = 1'b1;
    while (n < 200) begin
      @(posedge clk); n++; #1;
      if (pop_on_cap && n == 2) out_ready = 1'b1;
      if (pop_on_cap && n == 3) out_ready = 1'b0;
      if (ack) break;
    end
    if (!ack) fail_now("ack_timeout");
    else if (chk_lat) check("ack_latency", n, 3);
    #1 send = 1'b0;
    wait_ack_low();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit last_lat);
    for (int i = 0; i < int'(W); i++) begin
      if (i == int'(W) - 1) exp_q.push_back(w);
      send_bit(w[i], (i != int'(W) - 1) || last_lat, 1'b0);
    end
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #2 out_ready = 1'b1;
    while ((out_valid || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    #2 out_ready = 1'b0;
    @(negedge clk);
    check("drain_level", level, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] words[5];
    int rec0;
    bit seen;
    bit done;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_data", out_data, 0);
    @(posedge clk); #1 rst = 1'b1;

    // 0xA5 single word
    send_word(8'hA5, 1'b1);
    @(negedge clk);
    check("a5_valid", out_valid, 1);
    check("a5_data", out_data, 8'hA5);
    check("a5_level", level, 1);
    drain();

    // Fill to full, fifth word's last bit must wait for a pop
    rec0 = received;
    for (int k = 0; k < 5; k++) words[k] = W'($urandom);
    for (int k = 0; k < 4; k++) send_word(words[k], 1'b1);
    @(negedge clk);
    check("full_level", level, D);
    for (int i = 0; i < int'(W) - 1; i++) send_bit(words[4][i], 1'b1, 1'b0);
    exp_q.push_back(words[4]);
    @(posedge clk); #2 data = words[4][W-1];
    #1 send = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    check("blocked_ack", seen, 0);
    check("blocked_level", level, D);
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
    begin
      int n = 0;
      while (!ack && n < 20) begin
        @(posedge clk); #1; n++;
      end
      check("unblocked_ack", ack, 1);
    end
    send = 1'b0;
    wait_ack_low();
    check("after_unblock_level", level, D);
    drain();
    check("full_words_received", received - rec0, 5);

    // Push and pop on the same edge at level 2
    send_word(W'($urandom), 1'b1);
    send_word(W'($urandom), 1'b1);
    @(negedge clk);
    check("pp_level_before", level, 2);
    w = W'($urandom);
    for (int i = 0; i < int'(W) - 1; i++) send_bit(w[i], 1'b1, 1'b0);
    exp_q.push_back(w);
    send_bit(w[W-1], 1'b1, 1'b1);
    @(negedge clk);
    check("pp_level_after", level, 2);
    drain();

    // Reset mid-word while in HOLD
    send_word(W'($urandom), 1'b1);
    w = W'($urandom);
    for (int i = 0; i < 3; i++) send_bit(w[i], 1'b1, 1'b0);
    @(posedge clk); #2 data = w[3];
    #1 send = 1'b1;
    begin
      int n = 0;
      while (!ack && n < 20) begin
        @(posedge clk); #1; n++;
      end
      check("pre_reset_ack", ack, 1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ack", ack, 0);
    check("reset_level", level, 0);
    check("reset_valid", out_valid, 0);
    exp_q.delete();
    send = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send_word(8'h3C, 1'b1);
    @(negedge clk);
    check("post_reset_data", out_data, 8'h3C);
    check("post_reset_level", level, 1);
    drain();

    // Sub-cycle send glitch mid-word: no ack, no capture, bit position kept
    w = W'($urandom);
    for (int i = 0; i < 4; i++) send_bit(w[i], 1'b1, 1'b0);
    @(posedge clk); #2 data = ~w[4];
    send = 1'b1;
    #5 send = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    check("glitch_ack", seen, 0);
    for (int i = 4; i < int'(W); i++) begin
      if (i == int'(W) - 1) exp_q.push_back(w);
      send_bit(w[i], 1'b1, 1'b0);
    end
    @(negedge clk);
    check("glitch_word", out_data, w);
    drain();

    // Continuous streaming of 16 words
    rec0 = received;
    @(posedge clk); #2 out_ready = 1'b1;
    for (int k = 0; k < 16; k++) send_word(W'($urandom), 1'b1);
    drain();
    check("stream_received", received - rec0, 16);

    // Random consumer back-pressure
    rec0 = received;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++) send_word(W'($urandom), 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
      end
    join
    drain();
    check("random_received", received - rec0, 12);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
